// File: rtl/regfile_param.sv
// regfile_param: parametrised register bank between the AXI4-Lite slave
// control logic and the arithmetic datapath. Holds NUM_OPS operand
// registers, RESULT, CTRL, STATUS and LEDS, with byte-strobed writes,
// registered reads and a start/busy/done sequencer with timeout and IRQ.
// Illegal accesses raise o_wr_err / o_rd_err so the AXI side can answer
// with SLVERR.
//
// Word map (index = addr[7:2]):
//   0..NUM_OPS-1  OPk     RW
//   NUM_OPS       RESULT  RO
//   NUM_OPS+1     CTRL    [0] START (W1, self-clear), [1] IRQ_EN, [4+:OP_W] OP
//   NUM_OPS+2     STATUS  [0] BUSY RO, [1] DONE W1C, [2] TIMEOUT W1C
//   NUM_OPS+3     LEDS    RW
module regfile_param #(
  parameter int NUM_OPS     = 2,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 2,
  parameter int LED_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        ACLK,
  input  logic                        ARSTn,
  // write channel
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_addr_wc,
  input  logic [DATA_W-1:0]           i_data_wc,
  input  logic [DATA_W/8-1:0]         i_strb_wc,
  output logic                        o_wr_err,
  // read channel
  input  logic                        i_rd_en,
  input  logic [7:0]                  i_addr_rc,
  output logic [DATA_W-1:0]           o_data_rc,
  output logic                        o_rd_err,
  // datapath interface
  output logic                        o_start,
  output logic [OP_W-1:0]             o_op,
  output logic [NUM_OPS*DATA_W-1:0]   o_operands,
  input  logic                        i_result_valid,
  input  logic [DATA_W-1:0]           i_result,
  // status
  output logic                        o_busy,
  output logic                        o_irq,
  output logic [LED_W-1:0]            o_leds
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC);

  localparam logic [5:0] IDX_RESULT = 6'(NUM_OPS);
  localparam logic [5:0] IDX_CTRL   = 6'(NUM_OPS + 1);
  localparam logic [5:0] IDX_STATUS = 6'(NUM_OPS + 2);
  localparam logic [5:0] IDX_LEDS   = 6'(NUM_OPS + 3);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte-lane merge: only lanes with their strobe set take the new data.
  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] wdata,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_ops [NUM_OPS];
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_leds;
  logic              r_irq_en;
  logic [OP_W-1:0]   r_opcode;
  logic              r_done;
  logic              r_timeout;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start;
  logic              r_wr_err;
  logic [DATA_W-1:0] r_data_rc;
  logic              r_rd_err;

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic [5:0] w_wr_idx;
  logic       w_busy;
  logic       w_is_op;
  logic       w_is_result;
  logic       w_is_ctrl;
  logic       w_is_status;
  logic       w_is_leds;
  logic       w_wr_idx_ok;
  logic       w_lane0;
  logic       w_wr_err;
  logic       w_wr_ok;
  logic       w_start_req;
  logic       w_clr_done;
  logic       w_clr_timeout;
  logic       w_irq_en_upd;
  logic       w_take_result;
  logic       w_hit_timeout;

  assign w_wr_idx    = i_addr_wc[7:2];
  assign w_busy      = (r_state == S_BUSY);
  assign w_is_op     = (w_wr_idx <  IDX_RESULT);
  assign w_is_result = (w_wr_idx == IDX_RESULT);
  assign w_is_ctrl   = (w_wr_idx == IDX_CTRL);
  assign w_is_status = (w_wr_idx == IDX_STATUS);
  assign w_is_leds   = (w_wr_idx == IDX_LEDS);
  assign w_wr_idx_ok = (w_wr_idx <= IDX_LEDS);

  // START, IRQ_EN, OP, DONE and TIMEOUT all live in byte lane 0.
  assign w_lane0 = i_strb_wc[0];

  // Any CTRL write during BUSY is flagged: it may touch OP or START, both
  // of which are locked while the datapath is working.
  assign w_wr_err = i_wr_en & ( ~w_wr_idx_ok
                              | w_is_result
                              | (w_is_status & w_lane0 & i_data_wc[0])
                              | (w_is_op & w_busy)
                              | (w_is_ctrl & w_busy));

  assign w_wr_ok       = i_wr_en & ~w_wr_err;
  assign w_start_req   = w_wr_ok & w_is_ctrl   & w_lane0 & i_data_wc[0];
  assign w_clr_done    = w_wr_ok & w_is_status & w_lane0 & i_data_wc[1];
  assign w_clr_timeout = w_wr_ok & w_is_status & w_lane0 & i_data_wc[2];

  // IRQ_EN stays writable during BUSY even though the write is flagged.
  assign w_irq_en_upd  = i_wr_en & w_is_ctrl & w_lane0;

  // A result arriving in the timeout cycle wins over the timeout.
  assign w_take_result = w_busy & i_result_valid;
  assign w_hit_timeout = w_busy & ~i_result_valid & (r_cnt == CNT_LAST);

  // Sequencer: IDLE/DONE -> BUSY on START, BUSY -> DONE on result or timeout.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= '0;
    end else begin
      r_start <= 1'b0;
      if (w_clr_timeout && !w_busy) r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_req) begin
            r_state   <= S_BUSY;
            r_start   <= 1'b1;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_BUSY: begin
          // Setting DONE here takes priority over a W1C in the same cycle,
          // because the clear is only honoured in the DONE state.
          if (w_take_result) begin
            r_state  <= S_DONE;
            r_result <= i_result;
            r_done   <= 1'b1;
          end else if (w_hit_timeout) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (w_start_req) begin
            r_state   <= S_BUSY;
            r_start   <= 1'b1;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end else if (w_clr_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Software-writable registers: operands, LEDS, CTRL fields, error pulse.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      for (int k = 0; k < NUM_OPS; k++) r_ops[k] <= '0;
      r_leds   <= '0;
      r_irq_en <= 1'b0;
      r_opcode <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_err;
      for (int k = 0; k < NUM_OPS; k++) begin
        if (w_wr_ok && (w_wr_idx == 6'(k))) begin
          r_ops[k] <= f_merge(r_ops[k], i_data_wc, i_strb_wc);
        end
      end
      if (w_wr_ok && w_is_leds) begin
        r_leds <= f_merge(r_leds, i_data_wc, i_strb_wc);
      end
      if (w_irq_en_upd) begin
        r_irq_en <= i_data_wc[1];
      end
      if (w_wr_ok && w_is_ctrl && w_lane0) begin
        r_opcode <= i_data_wc[4 +: OP_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [5:0]        w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_idx_ok;

  assign w_rd_idx    = i_addr_rc[7:2];
  assign w_rd_idx_ok = (w_rd_idx <= IDX_LEDS);

  // Read mux; invalid indices return 0.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (w_rd_idx == 6'(k)) w_rd_data = r_ops[k];
    end
    if (w_rd_idx == IDX_RESULT) begin
      w_rd_data = r_result;
    end else if (w_rd_idx == IDX_CTRL) begin
      w_rd_data[1]         = r_irq_en;
      w_rd_data[4 +: OP_W] = r_opcode;
    end else if (w_rd_idx == IDX_STATUS) begin
      w_rd_data[0] = w_busy;
      w_rd_data[1] = r_done;
      w_rd_data[2] = r_timeout;
    end else if (w_rd_idx == IDX_LEDS) begin
      w_rd_data = r_leds;
    end
  end

  // Registered read response; data holds between reads, the error flag
  // is a pulse that accompanies the response cycle only.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_data_rc <= '0;
      r_rd_err  <= 1'b0;
    end else begin
      r_rd_err <= i_rd_en & ~w_rd_idx_ok;
      if (i_rd_en) r_data_rc <= w_rd_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_operands
    assign o_operands[k*DATA_W +: DATA_W] = r_ops[k];
  end

  assign o_wr_err  = r_wr_err;
  assign o_data_rc = r_data_rc;
  assign o_rd_err  = r_rd_err;
  assign o_start   = r_start;
  assign o_op      = r_opcode;
  assign o_busy    = w_busy;
  assign o_irq     = r_irq_en & r_done;
  assign o_leds    = r_leds[LED_W-1:0];

  // Byte-offset address bits are architecturally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_addr_wc[1:0], i_addr_rc[1:0]};

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the adder register bank. It sits between the AXI4-Lite slave control logic and the arithmetic datapath. It provides NUM_OPS operand registers, a result register, CTRL/STATUS/LEDS registers, byte-strobed writes, registered reads, and a start/busy/done sequencer with timeout and interrupt. Invalid or illegal accesses are flagged so the AXI control logic can return SLVERR.

Parameters:
NUM_OPS, 2, number of RW operand registers (1..8)
DATA_W, 32, register and bus width (multiple of 8)
OP_W, 2, opcode field width (1..4)
LED_W, 4, LED output width (1..DATA_W)
TIMEOUT_CYC, 1024, BUSY cycles before timeout (>=2)

Ports:
ACLK  in  1  clock
ARSTn  in  1  asynchronous active-low reset
i_wr_en  in  1  write strobe from AXI ctrl, one cycle per write
i_addr_wc  in  8  write byte address
i_data_wc  in  DATA_W  write data
i_strb_wc  in  DATA_W/8  byte enables
o_wr_err  out  1  write error, 1-cycle pulse, cycle after i_wr_en
i_rd_en  in  1  read strobe
i_addr_rc  in  8  read byte address
o_data_rc  out  DATA_W  read data, valid cycle after i_rd_en
o_rd_err  out  1  read error, aligned with o_data_rc
o_start  out  1  1-cycle start pulse to datapath
o_op  out  OP_W  latched opcode
o_operands  out  NUM_OPS*DATA_W  operand k at [k*DATA_W +: DATA_W]
i_result_valid  in  1  datapath result strobe
i_result  in  DATA_W  datapath result
o_busy  out  1  sequencer in BUSY
o_irq  out  1  level interrupt
o_leds  out  LED_W  LEDS[LED_W-1:0]

Behaviour:
- Address map, word index = addr[7:2]; addr[1:0] ignored. 0..NUM_OPS-1 OPk RW. NUM_OPS RESULT RO. NUM_OPS+1 CTRL. NUM_OPS+2 STATUS. NUM_OPS+3 LEDS RW. Any other index is invalid.
- CTRL: [0] START, write-1, self-clearing, reads 0. [1] IRQ_EN RW. [4+:OP_W] OP RW. Other bits read 0.
- STATUS: [0] BUSY RO. [1] DONE W1C. [2] TIMEOUT W1C. Other bits read 0.
- Reset (async assert, sync release): all registers 0; FSM IDLE; all outputs 0, including o_data_rc and both error flags.
- RW registers update only the bytes with i_strb_wc set. W1C and START act only when bytes with strb=0 leave the bit unaffected.
- Write error (write ignored, o_wr_err=1): invalid index; write to RESULT or STATUS[0]; write to OPk or CTRL.OP while BUSY; START=1 while BUSY. A write to CTRL while BUSY still updates IRQ_EN but flags the error.
- Read: registered, 1-cycle latency. An invalid index returns 0 with o_rd_err=1. o_data_rc holds its value when i_rd_en=0.
- FSM:
  - IDLE/DONE -> BUSY on a valid START write. o_start pulses the next cycle. DONE and TIMEOUT clear. Timeout counter loads 0.
  - BUSY + i_result_valid -> DONE. RESULT<=i_result. DONE<=1.
  - BUSY with counter reaching TIMEOUT_CYC-1 and no i_result_valid -> DONE. TIMEOUT<=1. DONE<=1. RESULT unchanged.
  - i_result_valid and timeout in the same cycle: result wins, TIMEOUT stays 0.
  - DONE -> IDLE when a W1C write clears DONE.
  - i_result_valid outside BUSY is ignored.
- DONE set and W1C clear in the same cycle: set wins.
- o_irq = IRQ_EN & DONE, combinational from registers.
- o_op and o_operands reflect the registers directly. They are stable throughout BUSY because writes are locked.
- Reset mid-BUSY: returns to IDLE with no o_start or irq.

Test Plan:
- Reset: after ARSTn release, read every index -> 0. o_irq=0, o_leds=0, rd_err=0 on valid indices, rd_err=1 on index 7 (NUM_OPS=2).
- Byte strobe: write OP0=0xAABBCCDD strb=0xF, then 0x11223344 strb=0x5 -> read 0xAA22CC44.
- Operation: OP0=5, OP1=7, CTRL=0x13 (START, IRQ_EN, OP=1) -> o_start 1 cycle, o_op=1, busy. Drive i_result_valid with 12 after 3 cycles -> RESULT=12, STATUS=0x2, o_irq=1. Write STATUS=0x2 -> STATUS=0, irq=0.
- Lockout: write OP0=9 or START while BUSY -> o_wr_err=1, OP0 unchanged, no o_start.
- Timeout: START with TIMEOUT_CYC=16 and no result -> after 16 BUSY cycles STATUS=0x6, RESULT unchanged. Result and timeout in the same cycle -> STATUS=0x2.
- Collision and reset: W1C DONE in the same cycle as a new DONE set -> DONE=1. Assert ARSTn mid-BUSY -> all 0, IDLE.
